// File: rtl/mem_common_pkg.sv
// Shared memory-side types for the front end: fetch request/response records
// plus the fetch-buffer state, line and tag types.
package mem_common;

  localparam int MC_PADDR_W    = 32;
  localparam int FB_LINE_BYTES = 64;
  localparam int FB_OFF_W      = $clog2(FB_LINE_BYTES);

  typedef logic [MC_PADDR_W-1:0] t_paddr;

  typedef struct packed {
    logic   valid;
    t_paddr addr;
    logic   id;
  } t_fe_fb_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    t_paddr      pc;
  } t_fb_fe_rsp;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_RSP,
    FB_MISS_REQ,
    FB_MISS_WAIT
  } t_fb_state;

  typedef logic [FB_LINE_BYTES*8-1:0]       t_fb_line;
  typedef logic [MC_PADDR_W-FB_OFF_W-1:0]   t_fb_tag;

  // Byte 0 of the line sits in bits [7:0], so word n is bits [32n+31:32n].
  function automatic logic [31:0] fb_word_sel(t_fb_line line, logic [FB_OFF_W-3:0] word);
    return line[word*32 +: 32];
  endfunction

endpackage

// File: rtl/fe_fb_tag_array.sv
// Fully-associative line storage for the fetch buffer: valid/tag/data per entry,
// one-hot tag match with word select, and a single install port.
module fe_fb_tag_array
  import mem_common::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int WORD_W      = FB_OFF_W - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  t_fb_tag                i_lookup_tag,
  input  logic [WORD_W-1:0]      i_lookup_word,
  output logic                   o_hit,
  output logic [NUM_ENTRIES-1:0] o_hit_vec,
  output logic [31:0]            o_hit_word,
  input  logic                   i_install_en,
  input  logic [IDX_W-1:0]       i_install_idx,
  input  t_fb_tag                i_install_tag,
  input  t_fb_line               i_install_line
);

  logic [NUM_ENTRIES-1:0] r_valid;
  t_fb_tag                r_tag  [NUM_ENTRIES];
  t_fb_line               r_data [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= '0;
    end else if (i_install_en) begin
      r_valid[i_install_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (i_install_en) begin
      r_tag[i_install_idx]  <= i_install_tag;
      r_data[i_install_idx] <= i_install_line;
    end
  end

  always_comb begin
    o_hit_vec  = '0;
    o_hit_word = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o_hit_vec[i] = r_valid[i] && (r_tag[i] == i_lookup_tag);
      if (o_hit_vec[i]) begin
        o_hit_word = o_hit_word | fb_word_sel(r_data[i], i_lookup_word);
      end
    end
  end

  assign o_hit = |o_hit_vec;

endmodule

// File: rtl/fe_fb.sv
// Fetch buffer between the fetch controller and memory: 1-cycle hits, line fills on miss.
// Define FE_FB_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module fe_fb
  import mem_common::*;
#(
  parameter int PADDR_W     = 32,
  parameter int LINE_BYTES  = 64,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  t_fe_fb_req              fe_fb_req_nnn,
  output t_fb_fe_rsp              fb_fe_rsp_nnn,
  input  logic                    flush_fb,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [PADDR_W-1:0]      mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_rsp_data,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  t_fb_state              r_state;
  t_fb_state              w_state_nxt;
  logic [PADDR_W-1:0]     r_addr;
  logic [31:0]            r_instr;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic                   r_poison;

  logic                   w_accept;
  logic                   w_hit_raw;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_fill;
  logic                   w_install;
  logic [NUM_ENTRIES-1:0] w_hit_vec;
  logic [31:0]            w_hit_word;
  logic                   w_unused;

  assign w_unused  = fe_fb_req_nnn.id;
  assign w_accept  = fe_fb_req_nnn.valid && ((r_state == FB_IDLE) || (r_state == FB_RSP));
  // A flush in the lookup cycle wins over a hit, so the request goes to memory.
  assign w_hit     = w_accept && w_hit_raw && !flush_fb;
  assign w_miss    = w_accept && !w_hit;
  assign w_fill    = (r_state == FB_MISS_WAIT) && mem_rsp_valid;
  assign w_install = w_fill && !r_poison && !flush_fb;

  fe_fb_tag_array #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_tag_array (
    .clk            (clk),
    .reset          (reset),
    .i_flush        (flush_fb),
    .i_lookup_tag   (fe_fb_req_nnn.addr[PADDR_W-1:OFF_W]),
    .i_lookup_word  (fe_fb_req_nnn.addr[OFF_W-1:2]),
    .o_hit          (w_hit_raw),
    .o_hit_vec      (w_hit_vec),
    .o_hit_word     (w_hit_word),
    .i_install_en   (w_install),
    .i_install_idx  (r_rr_ptr),
    .i_install_tag  (r_addr[PADDR_W-1:OFF_W]),
    .i_install_line (mem_rsp_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (r_state)
      FB_IDLE, FB_RSP: begin
        if (w_hit) begin
          w_state_nxt = FB_RSP;
        end else if (w_miss) begin
          w_state_nxt = FB_MISS_REQ;
        end else begin
          w_state_nxt = FB_IDLE;
        end
      end
      FB_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_req_ready) begin
          w_state_nxt = FB_MISS_WAIT;
        end
      end
      FB_MISS_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = FB_RSP;
        end
      end
      default: w_state_nxt = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FB_IDLE;
      r_addr   <= '0;
      r_instr  <= '0;
      r_rr_ptr <= '0;
      r_poison <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= fe_fb_req_nnn.addr;
      end
      if (w_hit) begin
        r_instr <= w_hit_word;
      end else if (w_fill) begin
        r_instr <= fb_word_sel(mem_rsp_data, r_addr[OFF_W-1:2]);
      end
      // A flush while the fill is in flight means the returning line may be stale.
      if (w_accept) begin
        r_poison <= 1'b0;
      end else if (flush_fb && ((r_state == FB_MISS_REQ) || (r_state == FB_MISS_WAIT))) begin
        r_poison <= 1'b1;
      end
      if (w_install) begin
        r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
    end
  end

  always_comb begin
    fb_fe_rsp_nnn       = '0;
    fb_fe_rsp_nnn.valid = (r_state == FB_RSP);
    fb_fe_rsp_nnn.instr = r_instr;
    fb_fe_rsp_nnn.pc    = r_addr;
  end

`ifdef FE_FB_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fe_fb_req_nnn.valid && ((r_state == FB_MISS_REQ) || (r_state == FB_MISS_WAIT))))
        else $error("fe_fb: request while a miss is outstanding");
      assert (!fe_fb_req_nnn.valid || (fe_fb_req_nnn.addr[1:0] == 2'b00))
        else $error("fe_fb: misaligned fetch address");
      assert (!w_accept || $onehot0(w_hit_vec))
        else $error("fe_fb: multiple tag matches");
      assert (!mem_rsp_valid || (r_state == FB_MISS_WAIT))
        else $error("fe_fb: fill data outside miss wait");
    end
  end

endmodule

// File: tb/tb_fe_fb.sv
// Randomized scoreboard bench for fe_fb: behavioural cache model, memory responder,
// and a monitor that checks every response against the expected queue.
module tb_fe_fb;
  import mem_common::*;

  localparam int NE = 4;
  localparam int W  = 65;  // {miss, instr, pc}

  logic        clk = 1'b0;
  logic        reset;
  t_fe_fb_req  req;
  t_fb_fe_rsp  rsp;
  logic        flush_fb;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [511:0] mem_rsp_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  fe_fb #(
    .PADDR_W     (32),
    .LINE_BYTES  (64),
    .NUM_ENTRIES (NE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fe_fb_req_nnn (req),
    .fb_fe_rsp_nnn (rsp),
    .flush_fb      (flush_fb),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int           n_checks = 0;
  int           n_errs   = 0;
  logic [W-1:0] exp_q[$];

  // reference cache: which lines are resident, and where the next install goes
  logic [25:0] m_tag   [NE];
  bit          m_valid [NE];
  int          m_rr     = 0;
  int          m_hits   = 0;
  int          m_misses = 0;

  // memory responder state
  bit          hold_rsp   = 1'b0;
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;
  bit          miss_seen  = 1'b0;
  logic [31:0] hs_addr    = '0;
  int          hs_cnt     = 0;
  bit          pend       = 1'b0;
  int          pend_dly   = 0;
  logic [31:0] pend_addr  = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_lookup(logic [31:0] a);
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && (m_tag[i] == a[31:6])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_flush();
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_install(input logic [31:0] a);
    m_tag[m_rr]   = a[31:6];
    m_valid[m_rr] = 1'b1;
    m_rr          = (m_rr + 1) % NE;
  endtask

  task automatic m_reset();
    m_flush();
    m_rr     = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // driver tasks
  task automatic send(input logic [31:0] a, input bit fl, input bit poison);
    bit hit;
    if (fl) m_flush();
    hit = m_lookup(a);
    if (hit) m_hits++;
    else     m_misses++;
    exp_q.push_back({!hit, mem_word(a), a});
    req.valid = 1'b1;
    req.addr  = a;
    req.id    = 1'($urandom_range(0, 1));
    flush_fb  = fl;
    @(negedge clk);
    req.valid = 1'b0;
    flush_fb  = 1'b0;
    if (!hit) begin
      if (poison) begin
        flush_fb = 1'b1;
        m_flush();
        @(negedge clk);
        flush_fb = 1'b0;
      end else begin
        m_install(a);
      end
    end
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (!rsp.valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rsp.valid) begin
      n_checks++;
      n_errs++;
      $display("FAIL rsp_timeout: got no response expected one within 100 cycles");
    end
  endtask

  task automatic idle_flush();
    flush_fb = 1'b1;
    m_flush();
    @(negedge clk);
    flush_fb = 1'b0;
  endtask

  task automatic check_counters(input string tag);
`ifdef FE_FB_STATS_EN
    check({tag, "_hit_cnt"},  128'(hit_cnt),  128'(m_hits));
    check({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(m_misses));
`else
    check({tag, "_hit_cnt"},  128'(hit_cnt),  128'(0));
    check({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(0));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp"},           128'(rsp),           128'(0));
    check({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(0));
    check({tag, "_mem_req_addr"},  128'(mem_req_addr),  128'(0));
    check_counters(tag);
  endtask

  // memory responder: random ready, optional forced stall, random fill latency
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend && !hold_rsp) begin
          if (pend_dly == 0) begin
            mem_rsp_valid = 1'b1;
            for (int w = 0; w < 16; w++) mem_rsp_data[w*32 +: 32] = mem_word(pend_addr + 32'(w * 4));
            pend = 1'b0;
          end else begin
            pend_dly--;
          end
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            check("req_addr_stable", 128'(mem_req_addr), 128'(stall_addr));
            stall_left--;
          end else if ($urandom_range(0, 1) == 1) begin
            mem_req_ready = 1'b1;
            hs_cnt++;
            hs_addr   = mem_req_addr;
            miss_seen = 1'b1;
            pend      = 1'b1;
            pend_addr = mem_req_addr;
            pend_dly  = $urandom_range(0, 3);
          end
        end
      end
    end
  end

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rsp.valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_rsp: got pc %0h expected no response", rsp.pc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_instr", 128'(rsp.instr), 128'(e[63:32]));
          check("rsp_pc",    128'(rsp.pc),    128'(e[31:0]));
          check("miss_flag", 128'(miss_seen), 128'(e[64]));
          if (e[64]) check("fill_addr", 128'(hs_addr), 128'({e[31:6], 6'b0}));
          miss_seen = 1'b0;
        end
      end
    end
  end

  // stimulus
  initial begin
    int h0;
    int k;
    logic [31:0] rr_seq[5];
    reset    = 1'b1;
    req      = '0;
    flush_fb = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // cold miss with memory holding off ready for 5 cycles
    stall_left = 5;
    stall_addr = 32'h100;
    h0 = hs_cnt;
    send(32'h100, 1'b0, 1'b0);
    wait_rsp();
    check("cold_miss_handshakes", 128'(hs_cnt - h0), 128'(1));

    // two hits, the first issued in the response cycle
    send(32'h104, 1'b0, 1'b0);
    wait_rsp();
    send(32'h108, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk);
    check("hits_no_mem_req", 128'(hs_cnt - h0), 128'(1));
    check_counters("after_hits");

    // round-robin wrap after a flush
    idle_flush();
    rr_seq = '{32'h000, 32'h040, 32'h080, 32'h0C0, 32'h100};
    foreach (rr_seq[i]) begin
      send(rr_seq[i], 1'b0, 1'b0);
      wait_rsp();
      @(negedge clk);
    end
    send(32'h000, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk);

    // flush during the fill: response still returned, line not kept
    send(32'h200, 1'b0, 1'b1);
    wait_rsp();
    @(negedge clk);
    send(32'h200, 1'b0, 1'b0);
    wait_rsp();
    send(32'h204, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk);

    // randomized traffic over a small line pool to force evictions
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 7)) * 32'd64 + 32'($urandom_range(0, 15)) * 32'd4;
      send(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      wait_rsp();
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) idle_flush();
      end
    end
    @(negedge clk);
    check_counters("after_random");

    // reset while waiting for fill data
    send(32'h380, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk);
    hold_rsp = 1'b1;
    h0 = hs_cnt;
    send(32'h340, 1'b0, 1'b0);
    k = 0;
    while (hs_cnt == h0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_test_handshake", 128'(hs_cnt - h0), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_reset();
    check_idle_outputs("mid_miss_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    miss_seen = 1'b0;
    hold_rsp  = 1'b0;
    repeat (10) @(negedge clk);
    check("no_rsp_after_reset", 128'(exp_q.size()), 128'(0));
    send(32'h380, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk);
    check_counters("after_reset");

    repeat (3) @(negedge clk);
    check("exp_queue_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
